// File: rtl/lane_pkg.sv
// Shared lane constants: default widths, position ceiling, scheduler FSM state codes.
// Latency: n/a (constants and a helper only).
// Backpressure: n/a.
package lane_pkg;

   localparam int N_UNITS_DEF    = 4;
   localparam int POS_W_DEF      = 9;
   localparam int DMG_W_DEF      = 8;
   localparam int ENGAGE_GAP_DEF = 1;

   // Enemy base sits at the top of the position range.
   localparam logic [POS_W_DEF-1:0] POS_MAX = '1;

   // Scheduler FSM state codes (plain constants so legacy tools can use them too).
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_SCAN_P  = 3'd1;
   localparam logic [2:0] ST_SCAN_E  = 3'd2;
   localparam logic [2:0] ST_RESOLVE = 3'd3;
   localparam logic [2:0] ST_ISSUE   = 3'd4;

   // Width of a unit index; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/lane_tick_scheduler_front_scan.sv
// Front-unit finder: walks one side's snapshot one unit per cycle, keeping the best alive unit.
// Latency: N cycles of en_i; result valid the cycle after last_o.
// Backpressure: none; the caller holds en_i for exactly N cycles.
// Ports: clk/reset, clr_i (restart before a scan), en_i (scan one unit), pos_i/alive_i (snapshot),
//        best_pos_o/best_idx_o/valid_o (front unit), last_o (final unit being scanned this cycle).
module front_scan
   import lane_pkg::*;
#(
   parameter int N        = N_UNITS_DEF,
   parameter int POS_W    = POS_W_DEF,
   parameter int IDX_W    = idx_w(N_UNITS_DEF),
   parameter bit MIN_MODE = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clr_i,
   input  logic               en_i,
   input  logic [N*POS_W-1:0] pos_i,
   input  logic [N-1:0]       alive_i,
   output logic [POS_W-1:0]   best_pos_o,
   output logic [IDX_W-1:0]   best_idx_o,
   output logic               valid_o,
   output logic               last_o
);

   logic [IDX_W-1:0] idx_q;
   logic [POS_W-1:0] best_pos_q;
   logic [IDX_W-1:0] best_idx_q;
   logic             valid_q;
   logic [POS_W-1:0] cur_pos;
   logic             better;
   logic             take;

   assign cur_pos = pos_i[idx_q*POS_W +: POS_W];
   // Strict compare: an equal position never displaces the earlier (lower-index) unit.
   assign better  = MIN_MODE ? (cur_pos < best_pos_q) : (cur_pos > best_pos_q);
   assign take    = en_i && alive_i[idx_q] && (!valid_q || better);
   assign last_o  = en_i && (idx_q == IDX_W'(N - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_q      <= '0;
         best_pos_q <= '0;
         best_idx_q <= '0;
         valid_q    <= 1'b0;
      end else if (clr_i) begin
         idx_q      <= '0;
         best_pos_q <= '0;
         best_idx_q <= '0;
         valid_q    <= 1'b0;
      end else if (en_i) begin
         idx_q <= last_o ? '0 : idx_q + 1'b1;
         if (take) begin
            best_pos_q <= cur_pos;
            best_idx_q <= idx_q;
            valid_q    <= 1'b1;
         end
      end
   end

   assign best_pos_o = best_pos_q;
   assign best_idx_o = best_idx_q;
   assign valid_o    = valid_q;

endmodule

// File: rtl/lane_tick_scheduler.sv
// Per-tick lane sequencer: snapshot both sides, find fronts, resolve engage/advance, strobe units.
// Latency: strobes appear 2*N+2 cycles after the tick cycle and last exactly one cycle.
// Backpressure: none; a tick while busy is dropped and flagged in sticky tick_overrun.
// Ports: clk/reset, tick, p_*/e_* unit state in (pos, alive, power), p_*/e_* strobes and damage out,
//        p_base_hit/e_base_hit, busy, tick_overrun.
module lane_tick_scheduler
   import lane_pkg::*;
#(
   parameter int N_UNITS    = N_UNITS_DEF,
   parameter int POS_W      = POS_W_DEF,
   parameter int DMG_W      = DMG_W_DEF,
   parameter int ENGAGE_GAP = ENGAGE_GAP_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     tick,
   input  logic [N_UNITS*POS_W-1:0] p_pos,
   input  logic [N_UNITS-1:0]       p_alive,
   input  logic [N_UNITS*DMG_W-1:0] p_power,
   input  logic [N_UNITS*POS_W-1:0] e_pos,
   input  logic [N_UNITS-1:0]       e_alive,
   input  logic [N_UNITS*DMG_W-1:0] e_power,
   output logic [N_UNITS-1:0]       p_move_en,
   output logic [N_UNITS-1:0]       p_dmg_en,
   output logic [N_UNITS*DMG_W-1:0] p_dmg_in,
   output logic [N_UNITS-1:0]       e_move_en,
   output logic [N_UNITS-1:0]       e_dmg_en,
   output logic [N_UNITS*DMG_W-1:0] e_dmg_in,
   output logic                     p_base_hit,
   output logic                     e_base_hit,
   output logic                     busy,
   output logic                     tick_overrun
);

   localparam int               IDX_W   = idx_w(N_UNITS);
   localparam logic [POS_W-1:0] POS_TOP = {POS_W{1'b1}};
   localparam logic [POS_W:0]   GAP_LIM = (POS_W+1)'(ENGAGE_GAP);

   logic [2:0] state_q, state_d;
   logic       accept;
   logic       overrun_q;

   logic [N_UNITS*POS_W-1:0] sp_pos_q, se_pos_q;
   logic [N_UNITS-1:0]       sp_alive_q, se_alive_q;
   logic [N_UNITS*DMG_W-1:0] sp_pow_q, se_pow_q;

   logic [POS_W-1:0] p_fpos, e_fpos;
   logic [IDX_W-1:0] p_fidx, e_fidx;
   logic             p_fvld, e_fvld, p_last, e_last;

   logic [N_UNITS-1:0]       p_blk, e_blk;
   logic [POS_W:0]           gap;
   logic                     engaged;
   logic [N_UNITS-1:0]       p_move_d, e_move_d, p_dmg_en_d, e_dmg_en_d;
   logic [N_UNITS*DMG_W-1:0] p_dmg_in_d, e_dmg_in_d;
   logic                     p_hit_d, e_hit_d;
   logic [N_UNITS-1:0]       p_move_q, e_move_q, p_dmg_en_q, e_dmg_en_q;
   logic [N_UNITS*DMG_W-1:0] p_dmg_in_q, e_dmg_in_q;
   logic                     p_hit_q, e_hit_q;

   assign accept = tick && (state_q == ST_IDLE);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (accept) state_d = ST_SCAN_P;
         ST_SCAN_P:  if (p_last) state_d = ST_SCAN_E;
         ST_SCAN_E:  if (e_last) state_d = ST_RESOLVE;
         ST_RESOLVE: state_d = ST_ISSUE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         overrun_q  <= 1'b0;
         sp_pos_q   <= '0;
         sp_alive_q <= '0;
         sp_pow_q   <= '0;
         se_pos_q   <= '0;
         se_alive_q <= '0;
         se_pow_q   <= '0;
      end else begin
         state_q <= state_d;
         if (tick && (state_q != ST_IDLE)) overrun_q <= 1'b1;
         if (accept) begin
            sp_pos_q   <= p_pos;
            sp_alive_q <= p_alive;
            sp_pow_q   <= p_power;
            se_pos_q   <= e_pos;
            se_alive_q <= e_alive;
            se_pow_q   <= e_power;
         end
      end
   end

   front_scan #(.N(N_UNITS), .POS_W(POS_W), .IDX_W(IDX_W), .MIN_MODE(1'b1)) u_scan_p (
      .clk(clk), .reset(reset), .clr_i(accept), .en_i(state_q == ST_SCAN_P),
      .pos_i(sp_pos_q), .alive_i(sp_alive_q),
      .best_pos_o(p_fpos), .best_idx_o(p_fidx), .valid_o(p_fvld), .last_o(p_last)
   );

   front_scan #(.N(N_UNITS), .POS_W(POS_W), .IDX_W(IDX_W), .MIN_MODE(1'b0)) u_scan_e (
      .clk(clk), .reset(reset), .clr_i(accept), .en_i(state_q == ST_SCAN_E),
      .pos_i(se_pos_q), .alive_i(se_alive_q),
      .best_pos_o(e_fpos), .best_idx_o(e_fidx), .valid_o(e_fvld), .last_o(e_last)
   );

   // A unit is blocked when a live teammate occupies the square it would step into.
   // Wrapped targets at the base squares are harmless: those units never move anyway.
   always_comb begin
      p_blk = '0;
      e_blk = '0;
      for (int i = 0; i < N_UNITS; i++) begin
         for (int j = 0; j < N_UNITS; j++) begin
            if (j != i) begin
               if (sp_alive_q[j] &&
                   (sp_pos_q[j*POS_W +: POS_W] == sp_pos_q[i*POS_W +: POS_W] - 1'b1))
                  p_blk[i] = 1'b1;
               if (se_alive_q[j] &&
                   (se_pos_q[j*POS_W +: POS_W] == se_pos_q[i*POS_W +: POS_W] + 1'b1))
                  e_blk[i] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      // One extra bit keeps a crossed-over pair (player behind enemy) from wrapping to a small gap.
      gap        = {1'b0, p_fpos} - {1'b0, e_fpos};
      engaged    = p_fvld && e_fvld && (p_fpos >= e_fpos) && (gap <= GAP_LIM);
      p_move_d   = '0;
      e_move_d   = '0;
      p_dmg_en_d = '0;
      e_dmg_en_d = '0;
      p_dmg_in_d = '0;
      e_dmg_in_d = '0;
      p_hit_d    = 1'b0;
      e_hit_d    = 1'b0;
      if (engaged) begin
         p_dmg_en_d[p_fidx]                 = 1'b1;
         p_dmg_in_d[p_fidx*DMG_W +: DMG_W]  = se_pow_q[e_fidx*DMG_W +: DMG_W];
         e_dmg_en_d[e_fidx]                 = 1'b1;
         e_dmg_in_d[e_fidx*DMG_W +: DMG_W]  = sp_pow_q[p_fidx*DMG_W +: DMG_W];
      end
      for (int i = 0; i < N_UNITS; i++) begin
         if (sp_alive_q[i] && (sp_pos_q[i*POS_W +: POS_W] == '0)) p_hit_d = 1'b1;
         if (se_alive_q[i] && (se_pos_q[i*POS_W +: POS_W] == POS_TOP)) e_hit_d = 1'b1;
         p_move_d[i] = sp_alive_q[i] && !(engaged && (p_fidx == IDX_W'(i))) &&
                       (sp_pos_q[i*POS_W +: POS_W] != '0) && !p_blk[i];
         e_move_d[i] = se_alive_q[i] && !(engaged && (e_fidx == IDX_W'(i))) &&
                       (se_pos_q[i*POS_W +: POS_W] != POS_TOP) && !e_blk[i];
      end
   end

   // Loaded in RESOLVE so they are visible for the ISSUE cycle only; zero otherwise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         p_move_q   <= '0;
         e_move_q   <= '0;
         p_dmg_en_q <= '0;
         e_dmg_en_q <= '0;
         p_dmg_in_q <= '0;
         e_dmg_in_q <= '0;
         p_hit_q    <= 1'b0;
         e_hit_q    <= 1'b0;
      end else if (state_q == ST_RESOLVE) begin
         p_move_q   <= p_move_d;
         e_move_q   <= e_move_d;
         p_dmg_en_q <= p_dmg_en_d;
         e_dmg_en_q <= e_dmg_en_d;
         p_dmg_in_q <= p_dmg_in_d;
         e_dmg_in_q <= e_dmg_in_d;
         p_hit_q    <= p_hit_d;
         e_hit_q    <= e_hit_d;
      end else begin
         p_move_q   <= '0;
         e_move_q   <= '0;
         p_dmg_en_q <= '0;
         e_dmg_en_q <= '0;
         p_dmg_in_q <= '0;
         e_dmg_in_q <= '0;
         p_hit_q    <= 1'b0;
         e_hit_q    <= 1'b0;
      end
   end

   assign p_move_en    = p_move_q;
   assign e_move_en    = e_move_q;
   assign p_dmg_en     = p_dmg_en_q;
   assign e_dmg_en     = e_dmg_en_q;
   assign p_dmg_in     = p_dmg_in_q;
   assign e_dmg_in     = e_dmg_in_q;
   assign p_base_hit   = p_hit_q;
   assign e_base_hit   = e_hit_q;
   assign busy         = (state_q != ST_IDLE);
   assign tick_overrun = overrun_q;

endmodule

// File: tb/tb_lane_tick_scheduler.sv
// Bench for lane_tick_scheduler: directed lane scenarios plus randomized ticks against a reference model.
// Latency: checks strobes exactly 10 cycles after each tick and zero on neighbouring cycles.
// Backpressure: exercises overlapping ticks and mid-scan reset.
module tb_lane_tick_scheduler;

   localparam int N  = 4;
   localparam int PW = 9;
   localparam int DW = 8;
   localparam int PMAX = 511;

   logic            clk = 1'b0;
   logic            reset, tick;
   logic [N*PW-1:0] p_pos, e_pos;
   logic [N-1:0]    p_alive, e_alive;
   logic [N*DW-1:0] p_power, e_power;
   logic [N-1:0]    p_move_en, p_dmg_en, e_move_en, e_dmg_en;
   logic [N*DW-1:0] p_dmg_in, e_dmg_in;
   logic            p_base_hit, e_base_hit, busy, tick_overrun;

   lane_tick_scheduler dut (
      .clk(clk), .reset(reset), .tick(tick),
      .p_pos(p_pos), .p_alive(p_alive), .p_power(p_power),
      .e_pos(e_pos), .e_alive(e_alive), .e_power(e_power),
      .p_move_en(p_move_en), .p_dmg_en(p_dmg_en), .p_dmg_in(p_dmg_in),
      .e_move_en(e_move_en), .e_dmg_en(e_dmg_en), .e_dmg_in(e_dmg_in),
      .p_base_hit(p_base_hit), .e_base_hit(e_base_hit),
      .busy(busy), .tick_overrun(tick_overrun)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int pp[N], pa[N], pw[N], ep[N], ea[N], ew[N];
   logic [N-1:0]    x_pmove, x_emove, x_pdmg, x_edmg, s_pmove, s_emove, s_pdmg, s_edmg;
   logic [N*DW-1:0] x_pdin, x_edin, s_pdin, s_edin;
   logic            x_phit, x_ehit, s_phit;
   logic            ovr_exp = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int clamp(input int v);
      return (v < 0) ? 0 : ((v > PMAX) ? PMAX : v);
   endfunction

   // Reference: fronts by min/max search, then engage and step rules on plain integers.
   task automatic model();
      int pf = -1;
      int ef = -1;
      bit eng, blk;
      x_pmove = '0; x_emove = '0; x_pdmg = '0; x_edmg = '0;
      x_pdin = '0; x_edin = '0; x_phit = 1'b0; x_ehit = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (pa[i] != 0 && (pf < 0 || pp[i] < pp[pf])) pf = i;
         if (ea[i] != 0 && (ef < 0 || ep[i] > ep[ef])) ef = i;
      end
      eng = (pf >= 0) && (ef >= 0) && (pp[pf] >= ep[ef]) && (pp[pf] - ep[ef] <= 1);
      if (eng) begin
         x_pdmg[pf] = 1'b1; x_pdin[pf*DW +: DW] = DW'(ew[ef]);
         x_edmg[ef] = 1'b1; x_edin[ef*DW +: DW] = DW'(pw[pf]);
      end
      for (int i = 0; i < N; i++) begin
         if (pa[i] != 0) begin
            if (pp[i] == 0) x_phit = 1'b1;
            else if (!(eng && i == pf)) begin
               blk = 0;
               for (int j = 0; j < N; j++) if (j != i && pa[j] != 0 && pp[j] == pp[i] - 1) blk = 1;
               x_pmove[i] = !blk;
            end
         end
         if (ea[i] != 0) begin
            if (ep[i] == PMAX) x_ehit = 1'b1;
            else if (!(eng && i == ef)) begin
               blk = 0;
               for (int j = 0; j < N; j++) if (j != i && ea[j] != 0 && ep[j] == ep[i] + 1) blk = 1;
               x_emove[i] = !blk;
            end
         end
      end
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         p_pos[i*PW +: PW]   = PW'(pp[i]);  e_pos[i*PW +: PW]   = PW'(ep[i]);
         p_power[i*DW +: DW] = DW'(pw[i]);  e_power[i*DW +: DW] = DW'(ew[i]);
         p_alive[i] = (pa[i] != 0);         e_alive[i] = (ea[i] != 0);
      end
   endtask

   // Disturb the live inputs without touching the model's view of the lane.
   task automatic scramble();
      for (int i = 0; i < N; i++) begin
         p_pos[i*PW +: PW]   = PW'($urandom);  e_pos[i*PW +: PW]   = PW'($urandom);
         p_power[i*DW +: DW] = DW'($urandom);  e_power[i*DW +: DW] = DW'($urandom);
      end
      p_alive = N'($urandom);
      e_alive = N'($urandom);
   endtask

   // Clustered positions so blocking, ties, engagement and base hits all occur.
   task automatic rand_case();
      int sel, c, r;
      sel = int'($urandom_range(0, 3));
      c = (sel == 0) ? int'($urandom_range(0, 3)) :
          (sel == 1) ? int'($urandom_range(508, 511)) : int'($urandom_range(0, 511));
      for (int i = 0; i < N; i++) begin
         r = int'($urandom_range(0, 5)); pp[i] = clamp(c + r - 1);
         r = int'($urandom_range(0, 5)); ep[i] = clamp(c - r + 1);
         pa[i] = int'($urandom_range(0, 1)); ea[i] = int'($urandom_range(0, 1));
         pw[i] = int'($urandom_range(0, 255)); ew[i] = int'($urandom_range(0, 255));
      end
   endtask

   // Called at a falling edge; the tick is sampled at the next rising edge.
   task automatic run_tick(input bit overlap);
      logic [63:0] acc;
      model();
      drive();
      tick = 1'b1;
      @(negedge clk); tick = 1'b0;                  // tick+1
      chk("busy_start", busy, 1);
      repeat (2) @(negedge clk);                    // tick+3
      scramble();
      if (overlap) tick = 1'b1;
      @(negedge clk); tick = 1'b0;                  // tick+4
      if (overlap) begin
         ovr_exp = 1'b1;
         chk("overrun_set", tick_overrun, 1);
      end
      repeat (5) @(negedge clk);                    // tick+9
      chk("pre_issue_zero", {p_move_en, e_move_en, p_dmg_en, e_dmg_en, p_base_hit, e_base_hit}, 0);
      @(negedge clk);                               // tick+10
      s_pmove = p_move_en; s_emove = e_move_en; s_pdmg = p_dmg_en; s_edmg = e_dmg_en;
      s_pdin = p_dmg_in; s_edin = e_dmg_in; s_phit = p_base_hit;
      chk("p_move_en", p_move_en, x_pmove);
      chk("e_move_en", e_move_en, x_emove);
      chk("p_dmg_en", p_dmg_en, x_pdmg);
      chk("e_dmg_en", e_dmg_en, x_edmg);
      chk("p_dmg_in", p_dmg_in, x_pdin);
      chk("e_dmg_in", e_dmg_in, x_edin);
      chk("base_hit", {p_base_hit, e_base_hit}, {x_phit, x_ehit});
      chk("busy_issue", busy, 1);
      @(negedge clk);                               // tick+11
      chk("post_issue_zero", {p_move_en, e_move_en, p_dmg_en, e_dmg_en, p_base_hit, e_base_hit}, 0);
      chk("post_issue_dmg", {p_dmg_in, e_dmg_in}, 0);
      chk("busy_end", busy, 0);
      chk("overrun_flag", tick_overrun, ovr_exp);
      if (overlap) begin
         acc = '0;
         repeat (12) begin
            @(negedge clk);
            acc = acc | {p_move_en, e_move_en, p_dmg_en, e_dmg_en, busy};
         end
         chk("single_issue", acc, 0);
      end
   endtask

   initial begin
      reset = 1'b1; tick = 1'b0;
      p_pos = '0; e_pos = '0; p_alive = '0; e_alive = '0; p_power = '0; e_power = '0;
      repeat (3) @(negedge clk);
      chk("rst_strobes", {p_move_en, e_move_en, p_dmg_en, e_dmg_en, p_base_hit, e_base_hit}, 0);
      chk("rst_dmg_in", {p_dmg_in, e_dmg_in}, 0);
      chk("rst_busy_ovr", {busy, tick_overrun}, 0);
      reset = 1'b0;
      @(negedge clk);

      // Advance with a dead tail and a distant enemy.
      pp = '{200, 220, 0, 0}; pa = '{1, 1, 0, 0}; pw = '{1, 2, 3, 4};
      ep = '{50, 0, 0, 0};    ea = '{1, 0, 0, 0}; ew = '{5, 6, 7, 8};
      run_tick(1'b0);
      chk("dir_advance_p", s_pmove, 4'b0011);
      chk("dir_advance_e", s_emove, 4'b0001);
      chk("dir_advance_nodmg", {s_pdmg, s_edmg}, 0);

      // Adjacent fronts fight.
      pp = '{101, 300, 0, 0}; pa = '{1, 1, 0, 0}; pw = '{16, 9, 0, 0};
      ep = '{100, 40, 0, 0};  ea = '{1, 0, 0, 0}; ew = '{32, 0, 0, 0};
      run_tick(1'b0);
      chk("dir_engage_pdin", s_pdin[DW-1:0], 32);
      chk("dir_engage_edin", s_edin[DW-1:0], 16);
      chk("dir_engage_pmove", s_pmove, 4'b0010);

      // Queue blocking and equal-position tie at the front.
      pp = '{151, 150, 150, 400}; pa = '{1, 1, 1, 1}; pw = '{1, 2, 3, 4};
      ep = '{149, 0, 0, 0};       ea = '{1, 0, 0, 0}; ew = '{7, 0, 0, 0};
      run_tick(1'b0);
      chk("dir_tie_pdmg", s_pdmg, 4'b0010);
      chk("dir_block_pmove", s_pmove, 4'b1100);

      // Player at its base, enemy side wiped out.
      pp = '{0, 5, 0, 0}; pa = '{1, 1, 0, 0}; pw = '{1, 1, 0, 0};
      ep = '{0, 0, 0, 0}; ea = '{0, 0, 0, 0}; ew = '{0, 0, 0, 0};
      run_tick(1'b0);
      chk("dir_base_hit", s_phit, 1);
      chk("dir_base_move", s_pmove, 4'b0010);

      // Overlapping tick, then reset clears the sticky flag.
      rand_case();
      run_tick(1'b1);
      reset = 1'b1; #1;
      chk("overrun_cleared", tick_overrun, 0);
      ovr_exp = 1'b0;
      @(negedge clk); reset = 1'b0;
      @(negedge clk);

      // Reset during the enemy scan aborts the tick.
      rand_case();
      drive(); tick = 1'b1;
      @(negedge clk); tick = 1'b0;                  // tick+1
      repeat (5) @(negedge clk);                    // tick+6, enemy scan
      reset = 1'b1; #1;
      chk("abort_busy", busy, 0);
      chk("abort_strobes", {p_move_en, e_move_en, p_dmg_en, e_dmg_en, p_base_hit, e_base_hit}, 0);
      @(negedge clk); reset = 1'b0;
      begin
         logic [63:0] acc;
         acc = '0;
         repeat (8) begin
            @(negedge clk);
            acc = acc | {p_move_en, e_move_en, p_dmg_en, e_dmg_en, busy};
         end
         chk("abort_no_issue", acc, 0);
      end
      rand_case();
      run_tick(1'b0);

      for (int k = 0; k < 40; k++) begin
         rand_case();
         run_tick(1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
